// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised integer register file with an integrated scoreboard.
// Register x0 is hardwired to zero. Every other register has a pending bit:
// the issue stage sets it when it reserves a destination register, and
// writeback clears it when the result arrives. A pipelined or multi-cycle
// core uses these bits to detect RAW hazards (rsN_busy) and WAW hazards
// (iss_ready).
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a writeback in the current cycle is forwarded to the read
//               ports (data and busy) in that same cycle.
//   undefined : reads return the stored value and the stored pending bit.
//               A written value becomes visible one cycle after writeback.
//
// Parameters
//   XLEN        data width in bits
//   AW          register address width; NREG = 2**AW registers
//   RST_PATTERN contents after reset: 0 = all zero, 1 = register k holds 2*k
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   rs1, rs2   read addresses
//   rd1_data   read data for rs1 (combinational)
//   rd2_data   read data for rs2 (combinational)
//   rs1_busy   operand 1 is pending and not forwarded
//   rs2_busy   operand 2 is pending and not forwarded
//   iss_valid  issue stage requests a reservation of iss_rd
//   iss_rd     destination register to reserve
//   iss_ready  the reservation can be accepted this cycle
//   wb_valid   writeback strobe
//   wb_rd      writeback destination register
//   wb_data    writeback data
//   pend_cnt   registered count of pending registers
//
// Issue handshake: a reservation is accepted on a rising edge where
// iss_valid && iss_ready. iss_ready depends only on iss_rd and the stored
// pending bits, never on iss_valid or on a same-cycle writeback, so the issue
// stage may hold iss_valid high until it sees iss_ready. Writeback has no
// ready signal; it is always accepted.
// ----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN        = 32,
    parameter int AW          = 5,
    parameter int RST_PATTERN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1_data,
    output logic [XLEN-1:0] rd2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     pend_cnt
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    logic [NREG-1:0] pending_next;
    logic [AW:0]     cnt_next;
    logic            wb_write;
    logic            set_pend;
    logic            clr_pend;
    logic            fwd1;
    logic            fwd2;

    // Reset contents of register k. x0 is always zero regardless of pattern.
    function automatic logic [XLEN-1:0] rst_value(input int k);
        logic [XLEN-1:0] v;
        v = '0;
        if (RST_PATTERN == 1 && k != 0) begin
            v = XLEN'(2 * k);
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Issue / writeback decode and scoreboard next state
    // ------------------------------------------------------------------
    assign iss_ready = !pending[iss_rd] || (iss_rd == '0);
    assign wb_write  = wb_valid && (wb_rd != '0);

    always_comb begin
        // A set can only happen on a register that is not pending, so a set
        // and a clear in the same cycle always touch different registers.
        set_pend = iss_valid && iss_ready && (iss_rd != '0);
        clr_pend = wb_write && pending[wb_rd];

        pending_next = pending;
        if (wb_write) begin
            pending_next[wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-register issue wins.
        if (set_pend) begin
            pending_next[iss_rd] = 1'b1;
        end

        cnt_next = pend_cnt;
        case ({set_pend, clr_pend})
            2'b10:   cnt_next = pend_cnt + CNT_ONE;
            2'b01:   cnt_next = pend_cnt - CNT_ONE;
            default: cnt_next = pend_cnt;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= rst_value(k);
            end
        end else if (wb_write) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wb_write && (wb_rd == rs1);
    assign fwd2 = wb_write && (wb_rd == rs2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        rd1_data = '0;
        rs1_busy = 1'b0;
        if (rs1 != '0) begin
            rd1_data = fwd1 ? wb_data : regs[rs1];
            rs1_busy = pending[rs1] && !fwd1;
        end
    end

    always_comb begin
        rd2_data = '0;
        rs2_busy = 1'b0;
        if (rs2 != '0) begin
            rd2_data = fwd2 ? wb_data : regs[rs2];
            rs2_busy = pending[rs2] && !fwd2;
        end
    end

    // The incremental counter must always track the pending vector.
    cnt_matches_popcount: assert property (
        @(posedge clk) disable iff (rst) pend_cnt == ($countones(pending))
    );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rs1 = '0;
    logic [AW-1:0]   rs2 = '0;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rd = '0;
    logic            iss_ready;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic [AW:0]     pend_cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .RST_PATTERN(1)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .pend_cnt(pend_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Reference model: plain arrays updated once per clock edge
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < NREG; k++) c += m_pend[k] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (BYPASS && wb_valid && int'(wb_rd) == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input int a);
        if (a == 0) return 1'b0;
        if (BYPASS && wb_valid && int'(wb_rd) == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic bit m_ready(input int a);
        return (a == 0) || !m_pend[a];
    endfunction

    function automatic logic [XLEN-1:0] m_rst_val(input int k);
        logic [XLEN-1:0] v;
        v = 2 * k;
        return v;
    endfunction

    // Advance one clock; model sees the inputs held across the edge.
    task automatic tick();
        bit accept;
        int ir;
        int wr;
        ir = int'(iss_rd);
        wr = int'(wb_rd);
        accept = iss_valid && m_ready(ir);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                m_regs[k] = m_rst_val(k);
                m_pend[k] = 1'b0;
            end
        end else begin
            if (wb_valid && wr != 0) begin
                m_regs[wr] = wb_data;
                m_pend[wr] = 1'b0;
            end
            if (accept && ir != 0) m_pend[ir] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        rst       = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd12;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE0000;
        tick();
        idle_inputs();
        rs1 = 5'd5; rs2 = 5'd31; iss_rd = 5'd7;
        #1;
        n_tests++;
        if (rd1_data !== 32'd10) begin
            n_fail++; $display("FAIL reset_rd1 got %0h expected %0h", rd1_data, 32'd10);
        end
        n_tests++;
        if (rd2_data !== 32'd62) begin
            n_fail++; $display("FAIL reset_rd2 got %0h expected %0h", rd2_data, 32'd62);
        end
        n_tests++;
        if (pend_cnt !== '0 || iss_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got cnt=%0d rdy=%0b b1=%0b b2=%0b expected 0 1 0 0",
                               pend_cnt, iss_ready, rs1_busy, rs2_busy);
        end
        rs1 = 5'd0;
        #1;
        n_tests++;
        if (rd1_data !== '0) begin
            n_fail++; $display("FAIL reset_x0 got %0h expected 0", rd1_data);
        end
    endtask

    task automatic test_reserve();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; rs1 = 5'd7;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b1 || pend_cnt !== 6'd1) begin
            n_fail++; $display("FAIL reserve_busy got busy=%0b cnt=%0d expected 1 1", rs1_busy, pend_cnt);
        end
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        n_tests++;
        if (iss_ready !== 1'b0) begin
            n_fail++; $display("FAIL waw_block got ready=%0b expected 0", iss_ready);
        end
        tick();
        iss_valid = 1'b0;
        #1;
        n_tests++;
        if (pend_cnt !== 6'd1 || rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL waw_nochange got cnt=%0d busy=%0b expected 1 1", pend_cnt, rs1_busy);
        end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b0 || rd1_data !== 32'hDEADBEEF || pend_cnt !== 6'd0) begin
            n_fail++; $display("FAIL wb_release got busy=%0b data=%0h cnt=%0d expected 0 deadbeef 0",
                               rs1_busy, rd1_data, pend_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_now;
        exp_now = BYPASS ? 32'h1234 : 32'd6;
        rs1 = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        #1;
        n_tests++;
        if (rd1_data !== exp_now || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL wb_same_cycle got data=%0h busy=%0b expected %0h 0", rd1_data, rs1_busy, exp_now);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        n_tests++;
        if (rd1_data !== 32'h1234) begin
            n_fail++; $display("FAIL wb_next_cycle got %0h expected 1234", rd1_data);
        end
    endtask

    task automatic test_x0();
        logic [AW:0] cnt_before;
        iss_valid = 1'b1; iss_rd = 5'd20;
        tick();
        cnt_before = pend_cnt;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        #1;
        n_tests++;
        if (iss_ready !== 1'b1 || rd1_data !== '0 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL x0_same_cycle got rdy=%0b data=%0h busy=%0b expected 1 0 0",
                               iss_ready, rd1_data, rs1_busy);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rd1_data !== '0 || rs1_busy !== 1'b0 || pend_cnt !== cnt_before || pend_cnt !== 6'(m_count())) begin
            n_fail++; $display("FAIL x0_after got data=%0h busy=%0b cnt=%0d expected 0 0 %0d",
                               rd1_data, rs1_busy, pend_cnt, m_count());
        end
    endtask

    task automatic test_same_cycle();
        int c0;
        c0 = m_count();
        iss_valid = 1'b1; iss_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        tick();
        idle_inputs();
        rs1 = 5'd9;
        #1;
        n_tests++;
        if (rd1_data !== 32'h55 || rs1_busy !== 1'b1 || pend_cnt !== 6'(c0 + 1)) begin
            n_fail++; $display("FAIL iss_wb_same_rd got data=%0h busy=%0b cnt=%0d expected 55 1 %0d",
                               rd1_data, rs1_busy, pend_cnt, c0 + 1);
        end
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        c0 = m_count();
        iss_valid = 1'b1; iss_rd = 5'd4;
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'hA5A5;
        tick();
        idle_inputs();
        rs1 = 5'd4; rs2 = 5'd2;
        #1;
        n_tests++;
        if (pend_cnt !== 6'(c0) || rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || rd2_data !== 32'hA5A5) begin
            n_fail++; $display("FAIL iss_wb_diff_rd got cnt=%0d b1=%0b b2=%0b d2=%0h expected %0d 1 0 a5a5",
                               pend_cnt, rs1_busy, rs2_busy, rd2_data, c0);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, NREG - 1));
            wb_valid  = ($urandom_range(0, 2) == 0);
            // Bias writebacks towards a small window so they often hit pending regs.
            wb_rd     = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) wb_rd = AW'($urandom_range(0, NREG - 1));
            wb_data   = $urandom;
            rs1       = AW'($urandom_range(0, NREG - 1));
            rs2       = ($urandom_range(0, 3) == 0) ? wb_rd : AW'($urandom_range(0, NREG - 1));
            #1;
            n_tests++;
            if (rd1_data !== m_read(int'(rs1)) || rd2_data !== m_read(int'(rs2)) ||
                rs1_busy !== m_busy(int'(rs1)) || rs2_busy !== m_busy(int'(rs2)) ||
                iss_ready !== m_ready(int'(iss_rd)) || pend_cnt !== 6'(m_count())) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d got d1=%0h d2=%0h b1=%0b b2=%0b rdy=%0b cnt=%0d expected %0h %0h %0b %0b %0b %0d",
                             i, rd1_data, rd2_data, rs1_busy, rs2_busy, iss_ready, pend_cnt,
                             m_read(int'(rs1)), m_read(int'(rs2)), m_busy(int'(rs1)), m_busy(int'(rs2)),
                             m_ready(int'(iss_rd)), m_count());
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit bad;
        for (int k = 1; k < NREG; k++) begin
            iss_valid = 1'b1; iss_rd = AW'(k);
            tick();
        end
        iss_valid = 1'b0;
        #1;
        n_tests++;
        if (pend_cnt !== 6'(NREG - 1)) begin
            n_fail++; $display("FAIL reserve_all got cnt=%0d expected %0d", pend_cnt, NREG - 1);
        end
        rst = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd1;
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h77777777;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (pend_cnt !== '0) begin
            n_fail++; $display("FAIL mid_reset_cnt got %0d expected 0", pend_cnt);
        end
        bad = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            rs1 = AW'(k); rs2 = AW'(NREG - 1 - k);
            #1;
            if (rd1_data !== m_rst_val(k) || rs1_busy !== 1'b0 ||
                rd2_data !== m_rst_val(NREG - 1 - k) || rs2_busy !== 1'b0) begin
                if (!bad) $display("FAIL mid_reset_array reg %0d got %0h busy=%0b expected %0h 0",
                                   k, rd1_data, rs1_busy, m_rst_val(k));
                bad = 1'b1;
            end
        end
        n_tests++;
        if (bad) n_fail++;
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_reserve();
        test_bypass();
        test_x0();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
